// File: rtl/foc_pkg.sv
// -----------------------------------------------------------------------------
// foc_pkg
// Shared definitions for the field-oriented-control current chain.
//   - Q1.15 constants used by the Clarke transform
//   - state encoding of the current_dq_transform sequencer
//   - width-generic saturation and Q15 rounding helpers
// The helpers work on 64-bit signed values so they can serve every
// datapath width in the chain. Callers sign-extend into 64 bits and then
// take the low bits of the result.
// -----------------------------------------------------------------------------
package foc_pkg;

    // 1/sqrt(3) and 1/3 in Q1.15
    localparam logic signed [15:0] INV_SQRT3 = 16'sd18919;
    localparam logic signed [15:0] ONE_THIRD = 16'sd10923;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CAL,
        ST_OFS,
        ST_CLK_A,
        ST_CLK_B,
        ST_PK0,
        ST_PK1,
        ST_PK2,
        ST_PK3,
        ST_OUT
    } state_t;

    // Clamp x into the signed range of a w-bit number.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    // Round-half-up of a Q15-scaled sum back to integer scale.
    function automatic logic signed [63:0] q15_round(input logic signed [63:0] x);
        return (x + 64'sd16384) >>> 15;
    endfunction

endpackage

// File: rtl/q15_mul_round.sv
// -----------------------------------------------------------------------------
// q15_mul_round
// Registered signed multiply-accumulate with Q15 round and saturate on the
// output. One instance is time-shared by the Clarke and Park stages.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : perform one multiply this cycle
//   clr        : 1 = load acc with a*b, 0 = acc += a*b (when en)
//   a          : signed AW-bit operand
//   b          : signed BW-bit Q1.15 operand
//   y          : round(acc) saturated to signed OW bits (combinational from acc)
//   ovf        : y was saturated
// -----------------------------------------------------------------------------
module q15_mul_round
    import foc_pkg::*;
#(
    parameter int AW = 14,
    parameter int BW = 16,
    parameter int OW = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [OW-1:0] y,
    output logic                 ovf
);

    localparam int PW    = AW + BW;
    // One guard bit: at most two products are ever summed.
    localparam int ACC_W = PW + 1;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0]      acc_x;
    logic signed [63:0]      rnd;
    logic signed [63:0]      sat;

    assign prod   = a * b;
    assign prod_x = {prod[PW-1], prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= clr ? prod_x : (acc + prod_x);
        end
    end

    // Rounding happens once on the final sum, never per product.
    assign acc_x = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    assign rnd   = q15_round(acc_x);
    assign sat   = sat_to_width(rnd, OW);
    assign y     = sat[OW-1:0];
    assign ovf   = (sat != rnd);

endmodule

// File: rtl/current_dq_transform.sv
// -----------------------------------------------------------------------------
// current_dq_transform
// Raw phase-current samples -> offset removal -> Clarke -> Park -> Id/Iq.
// A single shared Q15 MAC (q15_mul_round) is stepped through the Clarke and
// Park products by a small sequencer. Offsets can be recalibrated at runtime
// by averaging 2^CAL_SHIFT samples per phase.
//
// Sequence after an accepted sample:
//   OFS -> [CLK_A] -> CLK_B -> PK0 -> PK1 -> PK2 -> PK3 -> OUT -> IDLE
// CLK_A only exists for PHASES=3. oDone rises 7 (PHASES=2) or 8 (PHASES=3)
// edges after the accepting edge.
//
// Ports
//   iClk, iRst_n         : clock, asynchronous active-low reset
//   iSample_valid        : one-cycle strobe, iIu/iIv/iIw valid
//   iIu, iIv, iIw        : raw unsigned offset-binary samples (DW)
//   iSin, iCos           : signed Q1.15 rotor angle (TW)
//   iCal_start           : request offset recalibration
//   oId, oIq             : signed d/q currents (DW)
//   oDone                : pulse, oId/oIq updated
//   oBusy                : sequencer not in IDLE
//   oCal_done            : pulse at end of calibration
//   oSat                 : sticky until next accepted sample, any stage saturated
//   oOverrun             : pulse, a sample arrived while busy and was dropped
//
// Build option
//   CURRENT_LPF_EN : adds parameter LPF_SHIFT and a first-order low-pass
//                    y <- y + ((x - y) >>> LPF_SHIFT) on oId/oIq in OUT.
// -----------------------------------------------------------------------------
module current_dq_transform
    import foc_pkg::*;
#(
    parameter int DW        = 12,
    parameter int TW        = 16,
    parameter int PHASES    = 2,
    parameter int CAL_SHIFT = 4
`ifdef CURRENT_LPF_EN
    ,
    parameter int LPF_SHIFT = 3
`endif
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iSample_valid,
    input  logic [DW-1:0] iIu,
    input  logic [DW-1:0] iIv,
    input  logic [DW-1:0] iIw,
    input  logic [TW-1:0] iSin,
    input  logic [TW-1:0] iCos,
    input  logic          iCal_start,
    output logic [DW-1:0] oId,
    output logic [DW-1:0] oIq,
    output logic          oDone,
    output logic          oBusy,
    output logic          oCal_done,
    output logic          oSat,
    output logic          oOverrun
);

    // Clarke sums reach 4x a phase value, so operands carry two extra bits.
    localparam int AW = DW + 2;
    localparam int CW = DW + CAL_SHIFT;

    localparam logic signed [TW-1:0] K_INV_SQRT3 = TW'(INV_SQRT3);
    localparam logic signed [TW-1:0] K_ONE_THIRD = TW'(ONE_THIRD);

    state_t state;
    state_t state_nxt;

    // Index 0/1/2 = phase u/v/w
    logic        [DW-1:0] in_raw  [3];
    logic        [DW-1:0] raw     [3];
    logic        [DW-1:0] off     [3];
    logic        [CW-1:0] cal_acc [3];
    logic        [CW-1:0] cal_sum [3];
    logic signed [DW-1:0] ph      [3];

    logic signed [DW:0]   diff    [3];
    logic signed [63:0]   diff_x  [3];
    logic signed [63:0]   diff_s  [3];
    logic signed [DW-1:0] ph_n    [3];
    logic [2:0]           ph_ovf;
    logic                 ofs_sat;

    logic [CAL_SHIFT-1:0] cal_cnt;

    logic signed [TW-1:0] sin_r;
    logic signed [TW-1:0] cos_r;
    logic signed [DW-1:0] alpha;
    logic signed [DW-1:0] beta;
    logic signed [DW-1:0] d_res;

    logic signed [AW-1:0] iu_x;
    logic signed [AW-1:0] iv_x;
    logic signed [AW-1:0] iw_x;
    logic signed [AW-1:0] alpha_x;
    logic signed [AW-1:0] beta_x;
    logic signed [AW-1:0] clk_a_sum;
    logic signed [AW-1:0] clk_b_sum;

    logic                 mac_en;
    logic                 mac_clr;
    logic signed [AW-1:0] mac_a;
    logic signed [TW-1:0] mac_b;
    logic signed [DW-1:0] mac_y;
    logic                 mac_ovf;

    assign in_raw[0] = iIu;
    assign in_raw[1] = iIv;
    assign in_raw[2] = iIw;

    assign oBusy = (state != ST_IDLE);

    // Offset removal: (DW+1)-bit difference, clamped to signed DW.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            diff[i]   = {1'b0, raw[i]} - {1'b0, off[i]};
            diff_x[i] = {{(63-DW){diff[i][DW]}}, diff[i]};
            diff_s[i] = sat_to_width(diff_x[i], DW);
            ph_n[i]   = diff_s[i][DW-1:0];
            ph_ovf[i] = (diff_s[i] != diff_x[i]);
        end
    end

    // The w phase only matters when three-phase Clarke consumes it.
    assign ofs_sat = ph_ovf[0] | ph_ovf[1] | ((PHASES == 3) && ph_ovf[2]);

    // Calibration running sums include the sample being accepted this cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cal_sum[i] = cal_acc[i] + {{CAL_SHIFT{1'b0}}, in_raw[i]};
        end
    end

    assign iu_x    = {{2{ph[0][DW-1]}}, ph[0]};
    assign iv_x    = {{2{ph[1][DW-1]}}, ph[1]};
    assign iw_x    = {{2{ph[2][DW-1]}}, ph[2]};
    assign alpha_x = {{2{alpha[DW-1]}}, alpha};
    assign beta_x  = {{2{beta[DW-1]}}, beta};

    assign clk_a_sum = (iu_x <<< 1) - iv_x - iw_x;
    assign clk_b_sum = (PHASES == 3) ? (iv_x - iw_x) : (iu_x + (iv_x <<< 1));

    q15_mul_round #(
        .AW (AW),
        .BW (TW),
        .OW (DW)
    ) u_mac (
        .clk   (iClk),
        .rst_n (iRst_n),
        .en    (mac_en),
        .clr   (mac_clr),
        .a     (mac_a),
        .b     (mac_b),
        .y     (mac_y),
        .ovf   (mac_ovf)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and MAC schedule. The MAC result of a state is read back
    // (from the accumulator) in the following state.
    always_comb begin
        state_nxt = state;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        case (state)
            ST_IDLE: begin
                if (iCal_start) begin
                    state_nxt = ST_CAL;
                end else if (iSample_valid) begin
                    state_nxt = ST_OFS;
                end
            end
            ST_CAL: begin
                if (iSample_valid && (cal_cnt == '1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OFS: begin
                state_nxt = (PHASES == 3) ? ST_CLK_A : ST_CLK_B;
            end
            ST_CLK_A: begin
                mac_en    = 1'b1;
                mac_clr   = 1'b1;
                mac_a     = clk_a_sum;
                mac_b     = K_ONE_THIRD;
                state_nxt = ST_CLK_B;
            end
            ST_CLK_B: begin
                mac_en    = 1'b1;
                mac_clr   = 1'b1;
                mac_a     = clk_b_sum;
                mac_b     = K_INV_SQRT3;
                state_nxt = ST_PK0;
            end
            ST_PK0: begin
                mac_en    = 1'b1;
                mac_clr   = 1'b1;
                mac_a     = alpha_x;
                mac_b     = cos_r;
                state_nxt = ST_PK1;
            end
            ST_PK1: begin
                mac_en    = 1'b1;
                mac_a     = beta_x;
                mac_b     = sin_r;
                state_nxt = ST_PK2;
            end
            ST_PK2: begin
                mac_en    = 1'b1;
                mac_clr   = 1'b1;
                mac_a     = -alpha_x;
                mac_b     = sin_r;
                state_nxt = ST_PK3;
            end
            ST_PK3: begin
                mac_en    = 1'b1;
                mac_a     = beta_x;
                mac_b     = cos_r;
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef CURRENT_LPF_EN
    // The output registers double as the filter state.
    logic signed [DW:0]   lpf_d_diff;
    logic signed [DW:0]   lpf_q_diff;
    logic signed [DW:0]   lpf_d_step;
    logic signed [DW:0]   lpf_q_step;
    logic signed [DW-1:0] lpf_d_next;
    logic signed [DW-1:0] lpf_q_next;

    assign lpf_d_diff = {d_res[DW-1], d_res} - {oId[DW-1], oId};
    assign lpf_q_diff = {mac_y[DW-1], mac_y} - {oIq[DW-1], oIq};
    assign lpf_d_step = lpf_d_diff >>> LPF_SHIFT;
    assign lpf_q_step = lpf_q_diff >>> LPF_SHIFT;
    // The step never exceeds the distance to x, so the result stays in range.
    assign lpf_d_next = oId + lpf_d_step[DW-1:0];
    assign lpf_q_next = oIq + lpf_q_step[DW-1:0];
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 3; i++) begin
                raw[i]     <= '0;
                off[i]     <= {1'b1, {(DW-1){1'b0}}};
                cal_acc[i] <= '0;
                ph[i]      <= '0;
            end
            cal_cnt   <= '0;
            sin_r     <= '0;
            cos_r     <= '0;
            alpha     <= '0;
            beta      <= '0;
            d_res     <= '0;
            oId       <= '0;
            oIq       <= '0;
            oSat      <= 1'b0;
            oDone     <= 1'b0;
            oCal_done <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oDone     <= 1'b0;
            oCal_done <= 1'b0;
            oOverrun  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A simultaneous calibration request wins; the sample is dropped.
                    if (!iCal_start && iSample_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            raw[i] <= in_raw[i];
                        end
                        sin_r <= iSin;
                        cos_r <= iCos;
                        oSat  <= 1'b0;
                    end
                end
                ST_CAL: begin
                    if (iSample_valid) begin
                        cal_cnt <= cal_cnt + 1'b1;
                        if (cal_cnt == '1) begin
                            for (int i = 0; i < 3; i++) begin
                                off[i]     <= cal_sum[i][CW-1:CAL_SHIFT];
                                cal_acc[i] <= '0;
                            end
                            oCal_done <= 1'b1;
                        end else begin
                            for (int i = 0; i < 3; i++) begin
                                cal_acc[i] <= cal_sum[i];
                            end
                        end
                    end
                end
                // ---- stage: offset removal ----
                ST_OFS: begin
                    for (int i = 0; i < 3; i++) begin
                        ph[i] <= ph_n[i];
                    end
                    if (ofs_sat) begin
                        oSat <= 1'b1;
                    end
                end
                // ---- stage: Clarke alpha available ----
                ST_CLK_B: begin
                    alpha <= (PHASES == 3) ? mac_y : ph[0];
                    if ((PHASES == 3) && mac_ovf) begin
                        oSat <= 1'b1;
                    end
                end
                // ---- stage: Clarke beta available ----
                ST_PK0: begin
                    beta <= mac_y;
                    if (mac_ovf) begin
                        oSat <= 1'b1;
                    end
                end
                // ---- stage: Park d available ----
                ST_PK2: begin
                    d_res <= mac_y;
                    if (mac_ovf) begin
                        oSat <= 1'b1;
                    end
                end
                // ---- stage: Park q available, publish ----
                ST_OUT: begin
`ifdef CURRENT_LPF_EN
                    oId <= lpf_d_next;
                    oIq <= lpf_q_next;
`else
                    oId <= d_res;
                    oIq <= mac_y;
`endif
                    oDone <= 1'b1;
                    if (mac_ovf) begin
                        oSat <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (iSample_valid && (state != ST_IDLE) && (state != ST_CAL)) begin
                oOverrun <= 1'b1;
            end
        end
    end

endmodule
